// File: rtl/shift_pkg.sv
// Shared constants, operation encodings and FSM state type for the shift arbiter.
// SHIFT_ROTATE_EN (see shift_core) selects whether OP_ROR rotates or is rejected.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_RSV = 2'b11
  } shift_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shift datapath: left/right barrel shifters plus optional rotate.
// Build option: define SHIFT_ROTATE_EN to make OP_ROR rotate right; otherwise it is rejected.
module shift_left #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result
);
  logic [DATA_W-1:0] stage;

  always_comb begin
    stage = data;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (shamt[i]) stage = stage << (1 << i);
    end
    result = stage;
  end
endmodule

module shift_right #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [DATA_W-1:0]  result
);
  logic [DATA_W-1:0] stage;

  always_comb begin
    stage = data;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (shamt[i]) begin
        if (arith) stage = $signed(stage) >>> (1 << i);
        else       stage = stage >> (1 << i);
      end
    end
    result = stage;
  end
endmodule

module shift_core #(
  parameter int unsigned DATA_W  = shift_pkg::DATA_W,
  parameter int unsigned SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               err
);
  import shift_pkg::*;

  logic [DATA_W-1:0] sll_res;
  logic [DATA_W-1:0] sra_res;

  shift_left #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_sll (
    .data   (data),
    .shamt  (shamt),
    .result (sll_res)
  );

  shift_right #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_sra (
    .data   (data),
    .shamt  (shamt),
    .arith  (op == OP_SRA),
    .result (sra_res)
  );

`ifdef SHIFT_ROTATE_EN
  logic [DATA_W-1:0] ror_res;
  // A left shift by the full width yields zero, so shamt=0 returns data unchanged.
  assign ror_res = (data >> shamt) | (data << (DATA_W - shamt));
`endif

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (shift_op_t'(op))
      OP_SLL: result = sll_res;
      OP_SRA: result = sra_res;
`ifdef SHIFT_ROTATE_EN
      OP_ROR: result = ror_res;
`else
      OP_ROR: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end to shift_core with a registered, held result.
// Build option: SHIFT_ROTATE_EN enables OP_ROR inside shift_core.
module shift_arbiter #(
  parameter int unsigned DATA_W  = shift_pkg::DATA_W,
  parameter int unsigned SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0][1:0]         req_op,
  input  logic [1:0][DATA_W-1:0]  req_data,
  input  logic [1:0][SHAMT_W-1:0] req_shamt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);
  import shift_pkg::*;

  state_t            state;
  logic              last_grant;
  logic              gnt_vld;
  logic              gnt_id;
  logic [DATA_W-1:0] core_result;
  logic              core_err;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (req_valid)
      2'b01: begin gnt_vld = 1'b1; gnt_id = 1'b0;        end
      2'b10: begin gnt_vld = 1'b1; gnt_id = 1'b1;        end
      2'b11: begin gnt_vld = 1'b1; gnt_id = ~last_grant; end
      default: ;
    endcase
  end

  // Ready is gated by reset so nothing can appear accepted while reset is held.
  assign req_ready = (state == ST_IDLE && gnt_vld && !reset) ?
                     (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  shift_core #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_core (
    .op     (req_op[gnt_id]),
    .data   (req_data[gnt_id]),
    .shamt  (req_shamt[gnt_id]),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state      <= ST_HOLD;
            last_grant <= gnt_id;
            rsp_valid  <= 1'b1;
            busy       <= 1'b1;
            rsp_id     <= gnt_id;
            rsp_data   <= core_result;
            rsp_err    <= core_err;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; SHALL equal log2(DATA_W).
REQ-003 SHALL have ports, in this order:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i is requester i.
- req_ready  out  2  per-requester accept; a handshake is valid&ready on the same bit.
- req_op  in  2x2  per-requester operation, encoded per shift_pkg.
- req_data  in  2xDATA_W  per-requester operand.
- req_shamt  in  2xSHAMT_W  per-requester shift amount.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_data  out  DATA_W  shifted result.
- rsp_err  out  1  operation was reserved or unsupported.
- busy  out  1  high while a result is held.

Function
REQ-004 SHALL implement a 2-state FSM: IDLE and HOLD.
REQ-005 In IDLE, SHALL assert req_ready only on the granted bit; no more than one bit of req_ready SHALL be high.
REQ-006 Grant rule:
- only one valid: grant it.
- both valid: grant the requester not granted last (round robin).
- none valid: no grant.
REQ-007 On handshake in IDLE, SHALL register result, rsp_id and rsp_err, update last_grant, and enter HOLD; rsp_valid SHALL rise on the next cycle (latency 1).
REQ-008 In HOLD, req_ready SHALL be 2'b00, and rsp_valid=1, busy=1.
REQ-009 In HOLD, rsp_data, rsp_id and rsp_err SHALL stay stable until rsp_ready=1.
REQ-010 With rsp_valid&rsp_ready, SHALL return to IDLE; peak throughput is one result per 2 cycles.
REQ-011 Operations:
- OP_SLL (00): shift left, zero fill.
- OP_SRA (01): arithmetic shift right, sign fill.
- OP_ROR (10): see REQ-016.
- OP_RSV (11): rsp_err=1, rsp_data=0.
REQ-012 SHALL honour a shamt of 0 (result = operand) and a shamt of 31 with no wrap of the shift amount.
REQ-013 SHALL leave a request that is not granted pending; the requester must hold it stable; no request SHALL be dropped.

Reset
REQ-014 While reset is high, the block SHALL be in IDLE, with:
- rsp_valid=0, busy=0, req_ready=0.
- rsp_data=0, rsp_id=0, rsp_err=0.
- last_grant=1, so requester 0 wins the first conflict.
REQ-015 Reset asserted in HOLD SHALL discard the held result; no rsp_valid SHALL follow reset release without a new handshake.

Configuration
REQ-016 Macro SHIFT_ROTATE_EN:
- defined: OP_ROR SHALL rotate right by shamt, with rsp_err=0.
- undefined: OP_ROR SHALL behave as OP_RSV (rsp_err=1, rsp_data=0), and no rotate logic SHALL be synthesised.

Structure
REQ-017 Package shift_pkg SHALL hold the op encodings OP_SLL, OP_SRA, OP_ROR, OP_RSV, the FSM state type, and the DATA_W/SHAMT_W constants.
REQ-018 The combinational shift datapath SHALL sit in one sub-module, shift_core, which instantiates the existing left and right barrel shifters and the optional rotate.
REQ-019 Arbitration, the FSM and the output registers SHALL sit in shift_arbiter.

Verification
REQ-020 Basic shifts, each on requester 0 with rsp_ready=1:
- SLL data=0x00000001 shamt=31 -> rsp_data=0x80000000, rsp_err=0.
- SRA data=0x80000000 shamt=4 -> rsp_data=0xF8000000.
- rsp_valid exactly 1 cycle after the handshake.
REQ-021 Conflict after reset: both req_valid held high with distinct data:
- grants alternate 0,1,0,1.
- rsp_id matches each grant.
- req_ready never 2'b11.
REQ-022 Backpressure: rsp_ready low for 3 cycles in HOLD:
- rsp_data/rsp_id stable.
- req_ready=00 and busy=1 throughout.
- IDLE follows the cycle after rsp_ready rises.
REQ-023 Rotate op: OP_ROR data=0x00000001 shamt=1:
- with SHIFT_ROTATE_EN -> 0x80000000, rsp_err=0.
- without -> 0x00000000, rsp_err=1.
- OP_RSV -> rsp_err=1 in both builds.
REQ-024 Reset in HOLD: assert reset mid-HOLD -> rsp_valid drops asynchronously and stays 0 until a new handshake; the next conflict grants requester 0.
